imem_boot_loader: RTL and testbench

Loads the 64x32 instruction memory of the single-cycle MIPS core from a byte stream before execution, holding the core in reset until the image is complete. It is the write side of the instruction memory, whose only other user is the core's combinational read port. It sits between a byte source (UART receiver or testbench) and the instruction memory write port, and drives the core's reset.

---
 rtl/mips_pkg.sv | 17 +
 rtl/imem_boot_loader_byte_packer.sv | 48 ++++
 rtl/imem_boot_loader.sv | 163 ++++++++++++++++
 tb/tb_imem_boot_loader.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the single-cycle MIPS core, its instruction memory
// and the boot loader that fills that memory before the core runs.
package mips_pkg;

    localparam int IMEM_DEPTH     = 64;
    localparam int IMEM_AW        = 6;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } loader_state_e;

endpackage

// File: rtl/imem_boot_loader_byte_packer.sv
// byte_packer_4x8: assembles four stream bytes into one big-endian word and
// flags the cycle in which the fourth byte arrives.
module byte_packer_4x8
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_data_i,
    output logic [31:0] word_o,
    output logic        word_done_o
);

    logic [23:0] shift_q, shift_d;
    logic [1:0]  cnt_q, cnt_d;

    // The fourth byte is never stored; it completes the word combinationally.
    always_comb begin
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        word_done_o = 1'b0;
        word_o      = {shift_q, byte_data_i};
        if (clear_i) begin
            shift_d = '0;
            cnt_d   = '0;
        end else if (byte_valid_i) begin
            if (cnt_q == 2'(BYTES_PER_WORD - 1)) begin
                word_done_o = 1'b1;
                cnt_d       = '0;
            end else begin
                shift_d = {shift_q[15:0], byte_data_i};
                cnt_d   = cnt_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Instruction memory boot loader: fills imem from a header+payload byte stream
// and holds the core in reset until done. Optional trailing XOR checksum byte
// is enabled by defining IMEM_LOAD_CHECKSUM_EN.
module imem_boot_loader
    import mips_pkg::*;
#(
    parameter int DEPTH = IMEM_DEPTH,
    parameter int AW    = IMEM_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    input  logic          start,
    output logic          imem_we,
    output logic [AW-1:0] imem_wa,
    output logic [31:0]   imem_wd,
    output logic          cpu_rst,
    output logic          done,
    output logic          error
);

    loader_state_e state_q;
    logic [AW:0]   wordCount_q;
    logic [AW:0]   wordIdx_q;
    logic          inReady_q;
    logic          imemWe_q;
    logic [AW-1:0] imemWa_q;
    logic [31:0]   imemWd_q;
    logic          cpuRst_q;
    logic          done_q;
    logic          error_q;
`ifdef IMEM_LOAD_CHECKSUM_EN
    logic [7:0]    csum_q;
`endif

    logic        accept;
    logic        headerBad;
    logic        lastWord;
    logic [31:0] packWord;
    logic        packDone;

    assign accept    = in_valid & inReady_q;
    assign headerBad = (in_data == 8'd0) || (in_data > 8'(DEPTH));
    assign lastWord  = (wordIdx_q == (wordCount_q - (AW+1)'(1)));

    byte_packer_4x8 u_packer (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (accept && (state_q == ST_IDLE)),
        .byte_valid_i (accept && (state_q == ST_LOAD)),
        .byte_data_i  (in_data),
        .word_o       (packWord),
        .word_done_o  (packDone)
    );

    // done/cpu_rst follow the DONE state by one cycle when entered from LOAD,
    // so the core is released only after the final write has landed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wordCount_q <= '0;
            wordIdx_q   <= '0;
            inReady_q   <= 1'b1;
            imemWe_q    <= 1'b0;
            imemWa_q    <= '0;
            imemWd_q    <= '0;
            cpuRst_q    <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
`ifdef IMEM_LOAD_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            imemWe_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (headerBad) begin
                            state_q   <= ST_ERROR;
                            error_q   <= 1'b1;
                            inReady_q <= 1'b0;
                        end else begin
                            state_q     <= ST_LOAD;
                            wordCount_q <= in_data[AW:0];
                            wordIdx_q   <= '0;
`ifdef IMEM_LOAD_CHECKSUM_EN
                            csum_q      <= '0;
`endif
                        end
                    end
                end
                ST_LOAD: begin
`ifdef IMEM_LOAD_CHECKSUM_EN
                    if (accept) begin
                        csum_q <= csum_q ^ in_data;
                    end
`endif
                    if (packDone) begin
                        imemWe_q  <= 1'b1;
                        imemWa_q  <= wordIdx_q[AW-1:0];
                        imemWd_q  <= packWord;
                        wordIdx_q <= wordIdx_q + (AW+1)'(1);
                        if (lastWord) begin
`ifdef IMEM_LOAD_CHECKSUM_EN
                            state_q   <= ST_CHECK;
`else
                            state_q   <= ST_DONE;
                            inReady_q <= 1'b0;
`endif
                        end
                    end
                end
`ifdef IMEM_LOAD_CHECKSUM_EN
                ST_CHECK: begin
                    if (accept) begin
                        inReady_q <= 1'b0;
                        if (in_data == csum_q) begin
                            state_q  <= ST_DONE;
                            done_q   <= 1'b1;
                            cpuRst_q <= 1'b0;
                        end else begin
                            state_q <= ST_ERROR;
                            error_q <= 1'b1;
                        end
                    end
                end
`endif
                ST_DONE: begin
                    if (start) begin
                        state_q   <= ST_IDLE;
                        done_q    <= 1'b0;
                        cpuRst_q  <= 1'b1;
                        inReady_q <= 1'b1;
                    end else begin
                        done_q   <= 1'b1;
                        cpuRst_q <= 1'b0;
                    end
                end
                ST_ERROR: begin
                    if (start) begin
                        state_q   <= ST_IDLE;
                        error_q   <= 1'b0;
                        inReady_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready = inReady_q;
    assign imem_we  = imemWe_q;
    assign imem_wa  = imemWa_q;
    assign imem_wd  = imemWd_q;
    assign cpu_rst  = cpuRst_q;
    assign done     = done_q;
    assign error    = error_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed self-checking bench for imem_boot_loader; checksum scenarios are
// compiled in when IMEM_LOAD_CHECKSUM_EN is defined.
module tb_imem_boot_loader;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        start;
    logic        imem_we;
    logic [5:0]  imem_wa;
    logic [31:0] imem_wd;
    logic        cpu_rst;
    logic        done;
    logic        error;

    int checks;
    int errors;
    int wrCount;
    logic [5:0]  logWa [64];
    logic [31:0] logWd [64];

    imem_boot_loader #(.DEPTH(64), .AW(6)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .start    (start),
        .imem_we  (imem_we),
        .imem_wa  (imem_wa),
        .imem_wd  (imem_wd),
        .cpu_rst  (cpu_rst),
        .done     (done),
        .error    (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Records every memory write, sampled mid-cycle.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (wrCount < 64) begin
                logWa[wrCount] = imem_wa;
                logWd[wrCount] = imem_wd;
            end
            wrCount = wrCount + 1;
        end
    end

    task automatic sendByte(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycle();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic pulseStart();
        in_valid = 1'b0;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Ends a payload: sends the checksum byte when enabled, else waits one cycle.
    task automatic finishLoad(input logic [7:0] ck);
`ifdef IMEM_LOAD_CHECKSUM_EN
        sendByte(ck);
        in_valid = 1'b0;
`else
        in_valid = 1'b0;
        if (ck == 8'hxx) in_data = 8'h00;
        @(posedge clk);
        #1;
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (imem_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_we got %b want 0", imem_we); end
        checks++; if (imem_wa !== 6'd0) begin errors++; $display("[TB] FAIL reset_wa got %0d want 0", imem_wa); end
        checks++; if (imem_wd !== 32'd0) begin errors++; $display("[TB] FAIL reset_wd got %h want 0", imem_wd); end
        checks++; if (cpu_rst !== 1'b1) begin errors++; $display("[TB] FAIL reset_cpu_rst got %b want 1", cpu_rst); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b want 0", done); end
        checks++; if (error !== 1'b0) begin errors++; $display("[TB] FAIL reset_error got %b want 0", error); end
        rst = 1'b0;
        idleCycle();
    endtask

    task automatic test_two_word();
        wrCount = 0;
        sendByte(8'h02);
        sendByte(8'h8C); sendByte(8'h01); sendByte(8'h00); sendByte(8'h04);
        checks++; if (imem_we !== 1'b1) begin errors++; $display("[TB] FAIL w0_we got %b want 1", imem_we); end
        checks++; if (imem_wa !== 6'd0) begin errors++; $display("[TB] FAIL w0_wa got %0d want 0", imem_wa); end
        checks++; if (imem_wd !== 32'h8C010004) begin errors++; $display("[TB] FAIL w0_wd got %h want 8c010004", imem_wd); end
        sendByte(8'h01); sendByte(8'h09); sendByte(8'h50); sendByte(8'h20);
        in_valid = 1'b0;
        checks++; if (imem_we !== 1'b1) begin errors++; $display("[TB] FAIL w1_we got %b want 1", imem_we); end
        checks++; if (imem_wa !== 6'd1) begin errors++; $display("[TB] FAIL w1_wa got %0d want 1", imem_wa); end
        checks++; if (imem_wd !== 32'h01095020) begin errors++; $display("[TB] FAIL w1_wd got %h want 01095020", imem_wd); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL w1_done_early got %b want 0", done); end
        checks++; if (cpu_rst !== 1'b1) begin errors++; $display("[TB] FAIL w1_cpu_rst got %b want 1", cpu_rst); end
        finishLoad(8'hF1);
        checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL two_done got %b want 1", done); end
        checks++; if (cpu_rst !== 1'b0) begin errors++; $display("[TB] FAIL two_cpu_rst got %b want 0", cpu_rst); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL two_in_ready got %b want 0", in_ready); end
        checks++; if (wrCount !== 2) begin errors++; $display("[TB] FAIL two_wr_count got %0d want 2", wrCount); end
        pulseStart();
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL rearm_done got %b want 0", done); end
        checks++; if (cpu_rst !== 1'b1) begin errors++; $display("[TB] FAIL rearm_cpu_rst got %b want 1", cpu_rst); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rearm_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_bad_header(input logic [7:0] hdr);
        wrCount = 0;
        sendByte(hdr);
        in_valid = 1'b0;
        checks++; if (error !== 1'b1) begin errors++; $display("[TB] FAIL badhdr_%h_error got %b want 1", hdr, error); end
        checks++; if (cpu_rst !== 1'b1) begin errors++; $display("[TB] FAIL badhdr_%h_cpu_rst got %b want 1", hdr, cpu_rst); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL badhdr_%h_in_ready got %b want 0", hdr, in_ready); end
        idleCycle();
        idleCycle();
        checks++; if (wrCount !== 0) begin errors++; $display("[TB] FAIL badhdr_%h_writes got %0d want 0", hdr, wrCount); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL badhdr_%h_done got %b want 0", hdr, done); end
        pulseStart();
        checks++; if (error !== 1'b0) begin errors++; $display("[TB] FAIL badhdr_%h_clear got %b want 0", hdr, error); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL badhdr_%h_rearm got %b want 1", hdr, in_ready); end
    endtask

    task automatic test_toggle_valid();
        logic [7:0] bytes [5];
        bytes[0] = 8'h01; bytes[1] = 8'h20; bytes[2] = 8'h08;
        bytes[3] = 8'h00; bytes[4] = 8'h0A;
        wrCount = 0;
        for (int i = 0; i < 5; i++) begin
            checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL toggle_in_ready_%0d got %b want 1", i, in_ready); end
            sendByte(bytes[i]);
            if (i < 4) begin
                idleCycle();
            end
        end
        in_valid = 1'b0;
        checks++; if (imem_we !== 1'b1) begin errors++; $display("[TB] FAIL toggle_we got %b want 1", imem_we); end
        checks++; if (imem_wd !== 32'h2008000A) begin errors++; $display("[TB] FAIL toggle_wd got %h want 2008000a", imem_wd); end
        finishLoad(8'h22);
        checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL toggle_done got %b want 1", done); end
        checks++; if (wrCount !== 1) begin errors++; $display("[TB] FAIL toggle_wr_count got %0d want 1", wrCount); end
        checks++; if (logWa[0] !== 6'd0) begin errors++; $display("[TB] FAIL toggle_wa got %0d want 0", logWa[0]); end
        pulseStart();
    endtask

    task automatic test_reset_midload();
        sendByte(8'h05);
        for (int i = 0; i < 10; i++) begin
            sendByte(8'(8'h10 + i));
        end
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++; if (imem_wa !== 6'd0) begin errors++; $display("[TB] FAIL midrst_wa got %0d want 0", imem_wa); end
        checks++; if (imem_wd !== 32'd0) begin errors++; $display("[TB] FAIL midrst_wd got %h want 0", imem_wd); end
        checks++; if (imem_we !== 1'b0) begin errors++; $display("[TB] FAIL midrst_we got %b want 0", imem_we); end
        checks++; if (cpu_rst !== 1'b1) begin errors++; $display("[TB] FAIL midrst_cpu_rst got %b want 1", cpu_rst); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL midrst_in_ready got %b want 1", in_ready); end
        checks++; if (done !== 1'b0 || error !== 1'b0) begin errors++; $display("[TB] FAIL midrst_flags got %b%b want 00", done, error); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        idleCycle();
        wrCount = 0;
        sendByte(8'h01);
        sendByte(8'hDE); sendByte(8'hAD); sendByte(8'hBE); sendByte(8'hEF);
        finishLoad(8'h22);
        checks++; if (wrCount !== 1) begin errors++; $display("[TB] FAIL fresh_wr_count got %0d want 1", wrCount); end
        checks++; if (logWa[0] !== 6'd0) begin errors++; $display("[TB] FAIL fresh_wa got %0d want 0", logWa[0]); end
        checks++; if (logWd[0] !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL fresh_wd got %h want deadbeef", logWd[0]); end
        checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL fresh_done got %b want 1", done); end
        pulseStart();
    endtask

    task automatic test_full_depth();
        logic [7:0]  ck;
        logic [7:0]  idx;
        logic [31:0] expWord;
        ck = 8'h00;
        wrCount = 0;
        sendByte(8'h40);
        for (int i = 0; i < 64; i++) begin
            idx = 8'(i);
            expWord = {idx, 8'h5A, ~idx, idx ^ 8'hC3};
            for (int k = 3; k >= 0; k--) begin
                ck = ck ^ expWord[k*8 +: 8];
                sendByte(expWord[k*8 +: 8]);
            end
        end
        in_valid = 1'b0;
        checks++; if (imem_wa !== 6'd63) begin errors++; $display("[TB] FAIL full_last_wa got %0d want 63", imem_wa); end
        finishLoad(ck);
        checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL full_done got %b want 1", done); end
        checks++; if (wrCount !== 64) begin errors++; $display("[TB] FAIL full_wr_count got %0d want 64", wrCount); end
        for (int i = 0; i < 64; i++) begin
            idx = 8'(i);
            expWord = {idx, 8'h5A, ~idx, idx ^ 8'hC3};
            checks++; if (logWa[i] !== 6'(i)) begin errors++; $display("[TB] FAIL full_wa_%0d got %0d want %0d", i, logWa[i], i); end
            checks++; if (logWd[i] !== expWord) begin errors++; $display("[TB] FAIL full_wd_%0d got %h want %h", i, logWd[i], expWord); end
        end
        pulseStart();
    endtask

`ifdef IMEM_LOAD_CHECKSUM_EN
    task automatic test_checksum(input logic [7:0] ck, input logic expectOk);
        sendByte(8'h01);
        sendByte(8'h11); sendByte(8'h22); sendByte(8'h33); sendByte(8'h44);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL ck_%h_ready got %b want 1", ck, in_ready); end
        sendByte(ck);
        in_valid = 1'b0;
        checks++; if (done !== expectOk) begin errors++; $display("[TB] FAIL ck_%h_done got %b want %b", ck, done, expectOk); end
        checks++; if (error !== !expectOk) begin errors++; $display("[TB] FAIL ck_%h_error got %b want %b", ck, error, !expectOk); end
        checks++; if (cpu_rst !== !expectOk) begin errors++; $display("[TB] FAIL ck_%h_cpu_rst got %b want %b", ck, cpu_rst, !expectOk); end
        idleCycle();
        checks++; if (cpu_rst !== !expectOk) begin errors++; $display("[TB] FAIL ck_%h_cpu_rst_hold got %b want %b", ck, cpu_rst, !expectOk); end
        pulseStart();
    endtask
`endif

    initial begin
        checks   = 0;
        errors   = 0;
        wrCount  = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        start    = 1'b0;
        test_reset();
        test_two_word();
        test_bad_header(8'h00);
        test_bad_header(8'h41);
        test_toggle_valid();
        test_reset_midload();
        test_full_depth();
`ifdef IMEM_LOAD_CHECKSUM_EN
        test_checksum(8'h44, 1'b1);
        test_checksum(8'h45, 1'b0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
